// File: rtl/gpu_slot_sched_if.sv
// gpu_slot_sched_if: config bus, SDRAM sequencer strobes and scheduler outputs.
interface gpu_slot_sched_if #(
  parameter int NUM_CH = 8,
  parameter int PH_W   = 9,
  parameter int CYC_W  = 4,
  parameter int PHS_W  = 4
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [2:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic              ena_wr;
  logic [NUM_CH-1:0] ena_wdata;
  logic              ram_ref;
  logic [CYC_W-1:0]  ram_cyc;
  logic [PHS_W-1:0]  ram_ph;
  logic [PH_W-1:0]   ram_ph_ctr;
  logic [NUM_CH-1:0] grant;
  logic              clr;
  logic              conflict;
  modport master (
    output cfg_wr, cfg_ch, cfg_addr, cfg_wdata, ena_wr, ena_wdata,
    output ram_ref, ram_cyc, ram_ph, ram_ph_ctr,
    input  grant, clr, conflict
  );
  modport slave (
    input  cfg_wr, cfg_ch, cfg_addr, cfg_wdata, ena_wr, ena_wdata,
    input  ram_ref, ram_cyc, ram_ph, ram_ph_ctr,
    output grant, clr, conflict
  );
endinterface

// File: rtl/gpu_slot_sched.sv
// gpu_slot_sched: programmable SDRAM slot scheduler emitting per-channel grants, refresh clear pulses and a bank-conflict flag.
module gpu_slot_sched #(
  parameter int NUM_CH  = 8,
  parameter int PH_W    = 9,
  parameter int CYC_W   = 4,
  parameter int PHS_W   = 4,
  parameter int CLR_MAX = 3
) (
  input logic clk,
  input logic rst,
  gpu_slot_sched_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CC_W = $clog2(CLR_MAX + 1);
  typedef struct packed {
    logic [PH_W-1:0] lo;
    logic [PH_W-1:0] hi;
    logic [1:0]      step;
    logic [2:0]      offset;
    logic [1:0]      cyc_sel;
    logic [1:0]      ph_sel;
    logic [1:0]      bank;
    logic [2:0]      div;
    logic [2:0]      div_init;
  } cfg_t;
  cfg_t [NUM_CH-1:0]      cfg_q, cfg_d;
  logic [NUM_CH-1:0][2:0] dcnt_q, dcnt_d;
  logic [NUM_CH-1:0]      ena_q, ena_d, grant_q, grant_d, qual, hit, in_win, on_stride;
  logic [CC_W-1:0]        ccnt_q, ccnt_d;
  logic                   clr_q, clr_d, conflict_q, conflict_d;
  logic                   sel, same_bank, clr_stb;
  logic                   unused;
  assign unused = ^{bus.cfg_wdata[15:PH_W], bus.cfg_wdata[3:2]};
  always_comb begin
    sel = 1'b0;
    ena_d = bus.ena_wr ? bus.ena_wdata : ena_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = bus.cfg_wr && bus.cfg_ch == CH_W'(i);
      cfg_d[i] = cfg_q[i];
      if (sel)
        case (bus.cfg_addr)
          3'd0: cfg_d[i].lo = bus.cfg_wdata[PH_W-1:0];
          3'd1: cfg_d[i].hi = bus.cfg_wdata[PH_W-1:0];
          3'd2: {cfg_d[i].step, cfg_d[i].offset} = bus.cfg_wdata[4:0];
          3'd3: {cfg_d[i].cyc_sel, cfg_d[i].ph_sel, cfg_d[i].bank} = {bus.cfg_wdata[7:4], bus.cfg_wdata[1:0]};
          3'd4: {cfg_d[i].div, cfg_d[i].div_init} = bus.cfg_wdata[5:0];
          default: ;
        endcase
      // out-of-range strobe selects never qualify
      qual[i] = (int'(cfg_q[i].cyc_sel) < CYC_W) && (int'(cfg_q[i].ph_sel) < PHS_W) &&
                bus.ram_cyc[cfg_q[i].cyc_sel] && bus.ram_ph[cfg_q[i].ph_sel];
      hit[i] = dcnt_q[i] == 3'd0;
      in_win[i] = cfg_q[i].lo <= cfg_q[i].hi
                ? (bus.ram_ph_ctr >= cfg_q[i].lo && bus.ram_ph_ctr <= cfg_q[i].hi)
                : (bus.ram_ph_ctr >= cfg_q[i].lo || bus.ram_ph_ctr <= cfg_q[i].hi);
      on_stride[i] = ((bus.ram_ph_ctr[2:0] ^ cfg_q[i].offset) & (3'b111 >> (2'd3 - cfg_q[i].step))) == 3'd0;
      grant_d[i] = ena_q[i] && qual[i] && in_win[i] && on_stride[i] && hit[i];
      dcnt_d[i] = (sel && bus.cfg_addr == 3'd4) ? bus.cfg_wdata[2:0]
                : qual[i] ? (hit[i] ? cfg_q[i].div : dcnt_q[i] - 3'd1)
                : dcnt_q[i];
    end
  end
  always_comb begin
    same_bank = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      for (int j = i + 1; j < NUM_CH; j++)
        same_bank = same_bank || (grant_d[i] && grant_d[j] && cfg_q[i].bank == cfg_q[j].bank);
    conflict_d = same_bank || (conflict_q && !(bus.cfg_wr && bus.cfg_addr == 3'd7));
    clr_stb = bus.ram_cyc[CYC_W-1] && bus.ram_ph[PHS_W-1];
    clr_d = clr_stb && bus.ram_ref && ccnt_q < CC_W'(CLR_MAX);
    // ccnt counts pulses already emitted; line start clears it first
    ccnt_d = (clr_stb && bus.ram_ph_ctr == '0) ? '0
           : (clr_q && ccnt_q < CC_W'(CLR_MAX)) ? ccnt_q + 1'b1
           : ccnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg_q      <= '0;
      dcnt_q     <= '0;
      ena_q      <= '0;
      grant_q    <= '0;
      ccnt_q     <= '0;
      clr_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      dcnt_q     <= dcnt_d;
      ena_q      <= ena_d;
      grant_q    <= grant_d;
      ccnt_q     <= ccnt_d;
      clr_q      <= clr_d;
      conflict_q <= conflict_d;
    end
  assign bus.grant    = grant_q;
  assign bus.clr      = clr_q;
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_gpu_slot_sched.sv
// tb_gpu_slot_sched: scoreboard bench for gpu_slot_sched driving a synthetic 16-clock-per-phase SDRAM sequencer.
module tb_gpu_slot_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  gpu_slot_sched_if #(.NUM_CH(8), .PH_W(9), .CYC_W(4), .PHS_W(4)) bus ();
  gpu_slot_sched #(.NUM_CH(8), .PH_W(9), .CYC_W(4), .PHS_W(4), .CLR_MAX(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [8:0] m_lo [8];
  logic [8:0] m_hi [8];
  logic [1:0] m_step [8];
  logic [2:0] m_off [8];
  logic [1:0] m_cs [8];
  logic [1:0] m_ps [8];
  logic [1:0] m_bank [8];
  logic [2:0] m_div [8];
  logic [2:0] m_dcnt [8];
  logic [7:0] m_ena;
  logic       m_clr, m_conf;
  int         m_ccnt;
  logic [9:0] exp_q [$];
  int n_checks = 0, n_fail = 0;
  int k = 0;
  bit run = 0;
  int cnt [8];
  int n_clr, bad2;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lo[i] = '0; m_hi[i] = '0; m_step[i] = '0; m_off[i] = '0;
      m_cs[i] = '0; m_ps[i] = '0; m_bank[i] = '0; m_div[i] = '0; m_dcnt[i] = '0;
    end
    m_ena = '0; m_clr = 0; m_conf = 0; m_ccnt = 0;
  endtask
  task automatic model_step(output logic [9:0] e);
    logic [7:0] g;
    logic       sb, s;
    logic [8:0] c;
    if (rst) begin
      model_reset();
      e = '0;
      return;
    end
    c = bus.ram_ph_ctr;
    g = '0;
    sb = 0;
    for (int i = 0; i < 8; i++) begin
      bit q, w, st;
      q = bus.ram_cyc[m_cs[i]] && bus.ram_ph[m_ps[i]];
      w = (m_lo[i] <= m_hi[i]) ? (c >= m_lo[i] && c <= m_hi[i]) : (c >= m_lo[i] || c <= m_hi[i]);
      st = (int'(c) % (1 << m_step[i])) == (int'(m_off[i]) % (1 << m_step[i]));
      g[i] = m_ena[i] && q && w && st && m_dcnt[i] == 3'd0;
      if (bus.cfg_wr && int'(bus.cfg_ch) == i && bus.cfg_addr == 3'd4) m_dcnt[i] = bus.cfg_wdata[2:0];
      else if (q) m_dcnt[i] = (m_dcnt[i] == 3'd0) ? m_div[i] : 3'(m_dcnt[i] - 3'd1);
    end
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (g[i] && g[j] && m_bank[i] == m_bank[j]) sb = 1;
    s = bus.ram_cyc[3] && bus.ram_ph[3];
    e[9:2] = g;
    e[1] = s && bus.ram_ref && m_ccnt < 3;
    e[0] = sb || (m_conf && !(bus.cfg_wr && bus.cfg_addr == 3'd7));
    if (s && c == 9'd0) m_ccnt = 0;
    else if (m_clr && m_ccnt < 3) m_ccnt++;
    m_clr = e[1];
    m_conf = e[0];
    if (bus.cfg_wr)
      case (bus.cfg_addr)
        3'd0: m_lo[bus.cfg_ch] = bus.cfg_wdata[8:0];
        3'd1: m_hi[bus.cfg_ch] = bus.cfg_wdata[8:0];
        3'd2: begin m_step[bus.cfg_ch] = bus.cfg_wdata[4:3]; m_off[bus.cfg_ch] = bus.cfg_wdata[2:0]; end
        3'd3: begin
          m_cs[bus.cfg_ch] = bus.cfg_wdata[7:6];
          m_ps[bus.cfg_ch] = bus.cfg_wdata[5:4];
          m_bank[bus.cfg_ch] = bus.cfg_wdata[1:0];
        end
        3'd4: m_div[bus.cfg_ch] = bus.cfg_wdata[5:3];
        default: ;
      endcase
    if (bus.ena_wr) m_ena = bus.ena_wdata;
  endtask
  task automatic clear_stats();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    n_clr = 0;
    bad2 = 0;
  endtask
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    bus.ram_ph     = run ? 4'(1 << (k % 4)) : 4'd0;
    bus.ram_cyc    = run ? 4'(1 << ((k / 4) % 4)) : 4'd0;
    bus.ram_ph_ctr = run ? 9'((k / 16) % 512) : 9'd0;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("out", {bus.grant, bus.clr, bus.conflict}, exp_q.pop_front());
    if (run) begin
      for (int i = 0; i < 8; i++) if (bus.grant[i]) cnt[i]++;
      if (bus.grant[2] && bus.ram_ph_ctr >= 9'd11 && bus.ram_ph_ctr <= 9'd499) bad2++;
      if (bus.clr) n_clr++;
      k++;
    end
    bus.cfg_wr = 0;
    bus.ena_wr = 0;
  endtask
  task automatic cfg(input int ch, input int addr, input int data);
    bus.cfg_wr = 1;
    bus.cfg_ch = 3'(ch);
    bus.cfg_addr = 3'(addr);
    bus.cfg_wdata = 16'(data);
    tick();
  endtask
  initial begin
    bit found;
    bus.cfg_wr = 0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.ena_wr = 0; bus.ena_wdata = '0; bus.ram_ref = 0;
    bus.ram_cyc = '0; bus.ram_ph = '0; bus.ram_ph_ctr = '0;
    model_reset();
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 check("rst_out", {bus.grant, bus.clr, bus.conflict}, 0);
    @(negedge clk) rst = 0;
    cfg(0, 0, 0);   cfg(0, 1, 511); cfg(0, 2, 0);    cfg(0, 3, 'hC0); cfg(0, 4, 'h10);
    cfg(1, 0, 32);  cfg(1, 1, 63);  cfg(1, 2, 'h10); cfg(1, 3, 'h01);
    cfg(2, 0, 500); cfg(2, 1, 10);  cfg(2, 3, 'h52);
    cfg(3, 0, 100); cfg(3, 1, 200); cfg(3, 3, 'hA3);
    cfg(4, 0, 150); cfg(4, 3, 'hA3);
    bus.ena_wr = 1;
    bus.ena_wdata = 8'h07;
    cfg(4, 1, 300);
    bus.ram_ref = 1;
    run = 1;
    clear_stats();
    repeat (8192) tick();
    check("l0_ch0", cnt[0], 171);
    check("l0_ch1", cnt[1], 8);
    check("l0_ch2", cnt[2], 23);
    check("l0_ch2_gap", bad2, 0);
    check("l0_ch3_off", cnt[3], 0);
    check("l0_clr", n_clr, 3);
    check("l0_conf", bus.conflict, 0);
    clear_stats();
    for (int j = 0; j < 8192; j++) begin
      if (j == 0) begin bus.ena_wr = 1; bus.ena_wdata = 8'h1F; end
      if (j == 4800) begin
        check("conf_set", bus.conflict, 1);
        bus.cfg_wr = 1; bus.cfg_ch = 3'd0; bus.cfg_addr = 3'd7;
      end
      if (j == 4801) check("conf_clr", bus.conflict, 0);
      if (j == 5600) begin bus.ena_wr = 1; bus.ena_wdata = 8'h17; end
      tick();
    end
    check("l1_ch0", cnt[0], 171);
    check("l1_ch1", cnt[1], 8);
    check("l1_ch2", cnt[2], 23);
    check("l1_ch3", cnt[3], 101);
    check("l1_ch4", cnt[4], 151);
    check("l1_clr", n_clr, 3);
    cfg(0, 4, 'h01);
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      found = bus.grant[0];
    end
    check("rst_wait", found, 1);
    rst = 1;
    #1 check("rst_async", {bus.grant, bus.clr, bus.conflict}, 0);
    model_reset();
    exp_q.delete();
    repeat (2) tick();
    rst = 0;
    clear_stats();
    repeat (600) tick();
    check("post_rst_grant", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);
    check("post_rst_clr", n_clr, 3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
